// File: rtl/gate_bist_if.sv
// Controller/gate-side signal bundle for gate_bist_checker.
// master: controller plus the gate under test (drives start, gate_sel, y); slave: the checker.
interface gate_bist_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic [2:0]       gate_sel;
  logic             a;
  logic             b;
  logic             y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [1:0]       vec_idx;
  logic             fail_vld;
  logic [1:0]       fail_vec;

  modport master (
    output start, gate_sel, y,
    input  a, b, busy, done, pass, err_cnt, vec_idx, fail_vld, fail_vec
  );

  modport slave (
    input  start, gate_sel, y,
    output a, b, busy, done, pass, err_cnt, vec_idx, fail_vld, fail_vec
  );
endinterface

// File: rtl/gate_bist_checker.sv
// Exhaustive 2-input gate BIST: sweeps {a,b}=00..11, samples y after a settle window.
// Optional first-failure capture is built when GATE_BIST_FAILCAP_EN is defined.
module gate_bist_checker #(
  parameter int SETTLE_CYC = 2,
  parameter int NUM_PASSES = 1,
  parameter int ERR_W      = 8
) (
  input logic        clk,
  input logic        rst,
  gate_bist_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [7:0]       PASS_LAST   = 8'(NUM_PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic [7:0]       pass_cnt_q, pass_cnt_d;
  logic [1:0]       vec_q, vec_d;
  logic [2:0]       sel_q, sel_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic             mismatch;

  // Illegal selections (6, 7) are scored against NAND.
  function automatic logic expected_y(input logic [2:0] sel, input logic [1:0] ab);
    logic and_v, or_v, xor_v;
    and_v = ab[1] & ab[0];
    or_v  = ab[1] | ab[0];
    xor_v = ab[1] ^ ab[0];
    case (sel)
      3'd0:    return and_v;
      3'd1:    return or_v;
      3'd3:    return ~or_v;
      3'd4:    return xor_v;
      3'd5:    return ~xor_v;
      default: return ~and_v;
    endcase
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + ERR_W'(1);
  endfunction

  assign mismatch = (state_q == SAMPLE) && (bus.y != expected_y(sel_q, vec_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      pass_cnt_q <= '0;
      vec_q      <= '0;
      sel_q      <= '0;
      err_q      <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      pass_cnt_q <= pass_cnt_d;
      vec_q      <= vec_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
      pass_q     <= pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    pass_cnt_d = pass_cnt_q;
    vec_d      = vec_q;
    sel_d      = sel_q;
    err_d      = err_q;
    pass_d     = pass_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sel_d      = bus.gate_sel;
          err_d      = '0;
          pass_d     = 1'b0;
          pass_cnt_d = '0;
          vec_d      = '0;
          settle_d   = '0;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = SAMPLE;
        else                         settle_d = settle_q + 4'd1;
      end
      SAMPLE: begin
        if (mismatch) err_d = sat_inc(err_q);
        settle_d = '0;
        if (vec_q != 2'd3) begin
          vec_d   = vec_q + 2'd1;
          state_d = SETTLE;
        end else if (pass_cnt_q != PASS_LAST) begin
          pass_cnt_d = pass_cnt_q + 8'd1;
          vec_d      = '0;
          state_d    = SETTLE;
        end else begin
          // pass is resolved with the final sample already folded into err_d.
          vec_d   = '0;
          pass_d  = (err_d == '0) && (sel_q <= 3'd5);
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      SETTLE, SAMPLE: bus.busy = 1'b1;
      FINISH:         bus.done = 1'b1;
      default:        ;
    endcase
  end

  assign bus.a       = vec_q[1];
  assign bus.b       = vec_q[0];
  assign bus.vec_idx = vec_q;
  assign bus.err_cnt = err_q;
  assign bus.pass    = pass_q;

`ifdef GATE_BIST_FAILCAP_EN
  logic       fvld_q, fvld_d;
  logic [1:0] fvec_q, fvec_d;

  always_comb begin
    fvld_d = fvld_q;
    fvec_d = fvec_q;
    if (state_q == IDLE && bus.start) begin
      fvld_d = 1'b0;
      fvec_d = '0;
    end else if (mismatch && !fvld_q) begin
      fvld_d = 1'b1;
      fvec_d = vec_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fvld_q <= 1'b0;
      fvec_q <= '0;
    end else begin
      fvld_q <= fvld_d;
      fvec_q <= fvec_d;
    end
  end

  assign bus.fail_vld = fvld_q;
  assign bus.fail_vec = fvec_q;
`else
  assign bus.fail_vld = 1'b0;
  assign bus.fail_vec = 2'b00;
`endif

endmodule

// File: tb/tb_gate_bist_checker.sv
// Randomized bench for gate_bist_checker: three parameterizations, gate under test
// modelled as a 4-entry truth table, results predicted from truth-table differences.
module tb_gate_bist_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gate_bist_if #(.ERR_W(8)) if0 ();
  gate_bist_if #(.ERR_W(2)) if1 ();
  gate_bist_if #(.ERR_W(8)) if2 ();

  gate_bist_checker #(.SETTLE_CYC(2), .NUM_PASSES(1), .ERR_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  gate_bist_checker #(.SETTLE_CYC(1), .NUM_PASSES(4), .ERR_W(2)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  gate_bist_checker #(.SETTLE_CYC(2), .NUM_PASSES(3), .ERR_W(8)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  logic       start_r [3];
  logic [2:0] sel_r   [3];
  logic [3:0] tt_r    [3];

  logic       busy_w [3];
  logic       done_w [3];
  logic       pass_w [3];
  logic       a_w    [3];
  logic       b_w    [3];
  logic       fvld_w [3];
  logic [1:0] vidx_w [3];
  logic [1:0] fvec_w [3];
  logic [7:0] err_w  [3];

  // Gate under test: y = tt[{a,b}]
  assign if0.start = start_r[0]; assign if0.gate_sel = sel_r[0]; assign if0.y = tt_r[0][{if0.a, if0.b}];
  assign if1.start = start_r[1]; assign if1.gate_sel = sel_r[1]; assign if1.y = tt_r[1][{if1.a, if1.b}];
  assign if2.start = start_r[2]; assign if2.gate_sel = sel_r[2]; assign if2.y = tt_r[2][{if2.a, if2.b}];

  assign busy_w[0] = if0.busy; assign done_w[0] = if0.done; assign pass_w[0] = if0.pass;
  assign a_w[0] = if0.a; assign b_w[0] = if0.b; assign vidx_w[0] = if0.vec_idx;
  assign fvld_w[0] = if0.fail_vld; assign fvec_w[0] = if0.fail_vec; assign err_w[0] = if0.err_cnt;
  assign busy_w[1] = if1.busy; assign done_w[1] = if1.done; assign pass_w[1] = if1.pass;
  assign a_w[1] = if1.a; assign b_w[1] = if1.b; assign vidx_w[1] = if1.vec_idx;
  assign fvld_w[1] = if1.fail_vld; assign fvec_w[1] = if1.fail_vec; assign err_w[1] = {6'b0, if1.err_cnt};
  assign busy_w[2] = if2.busy; assign done_w[2] = if2.done; assign pass_w[2] = if2.pass;
  assign a_w[2] = if2.a; assign b_w[2] = if2.b; assign vidx_w[2] = if2.vec_idx;
  assign fvld_w[2] = if2.fail_vld; assign fvec_w[2] = if2.fail_vec; assign err_w[2] = if2.err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int settle_of(input int w);
    return (w == 1) ? 1 : 2;
  endfunction

  function automatic int passes_of(input int w);
    return (w == 0) ? 1 : ((w == 1) ? 4 : 3);
  endfunction

  function automatic int errmax_of(input int w);
    return (w == 1) ? 3 : 255;
  endfunction

  // Truth table indexed by {a,b}; illegal selections score as NAND.
  function automatic logic [3:0] ref_tt(input int sel);
    case (sel)
      0:       return 4'b1000;
      1:       return 4'b1110;
      3:       return 4'b0001;
      4:       return 4'b0110;
      5:       return 4'b1001;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic int popcnt4(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  // mode 0: plain start pulse; 1: random start/gate_sel noise while busy; 2: start held high through done.
  task automatic run(input int w, input logic [2:0] sel, input logic [3:0] tt, input int mode,
                     input bit launched, output bit relaunched);
    int         s, p, lat, exp_err, first, t;
    logic [3:0] diff;
    logic [1:0] ev;
    s       = settle_of(w);
    p       = passes_of(w);
    lat     = 4 * (s + 1) * p;
    diff    = tt ^ ref_tt(int'(sel));
    exp_err = popcnt4(diff) * p;
    if (exp_err > errmax_of(w)) exp_err = errmax_of(w);
    first = 0;
    for (int i = 3; i >= 0; i--) if (diff[i]) first = i;
    relaunched = 1'b0;
    tt_r[w] = tt;
    if (!launched) begin
      @(negedge clk);
      sel_r[w]   = sel;
      start_r[w] = 1'b1;
      @(negedge clk);
      start_r[w] = (mode == 2);
    end
    check("err_cleared", err_w[w], 0);
    check("pass_cleared", pass_w[w], 0);
    check("fail_vld_cleared", fvld_w[w], 0);
    for (int k = 0; k < lat; k++) begin
      ev = 2'((k / (s + 1)) % 4);
      check("busy_in_run", busy_w[w], 1);
      check("done_early", done_w[w], 0);
      check("vec_idx", vidx_w[w], ev);
      check("ab_vs_idx", {a_w[w], b_w[w]}, ev);
      if (mode == 1) begin
        start_r[w] = 1'($urandom);
        sel_r[w]   = 3'($urandom);
      end
      @(negedge clk);
    end
    if (mode != 2) start_r[w] = 1'b0;
    check("done_latency", done_w[w], 1);
    if (done_w[w] !== 1'b1) begin
      t = 0;
      while (done_w[w] !== 1'b1 && t < 400) begin
        @(negedge clk);
        t++;
      end
    end
    check("busy_at_done", busy_w[w], 0);
    check("ab_idle", {a_w[w], b_w[w]}, 0);
    check("err_cnt", err_w[w], exp_err);
    check("pass", pass_w[w], (exp_err == 0) && (sel <= 3'd5));
`ifdef GATE_BIST_FAILCAP_EN
    check("fail_vld", fvld_w[w], diff != 4'b0);
    if (diff != 4'b0) check("fail_vec", fvec_w[w], first);
`else
    check("fail_vld_tied", fvld_w[w], 0);
    check("fail_vec_tied", fvec_w[w], 0);
`endif
    @(negedge clk);
    check("done_one_cycle", done_w[w], 0);
    check("idle_after_done", busy_w[w], 0);
    check("pass_held", pass_w[w], (exp_err == 0) && (sel <= 3'd5));
    if (mode == 2) begin
      @(negedge clk);
      check("restart_after_done", busy_w[w], 1);
      start_r[w] = 1'b0;
      relaunched = 1'b1;
    end
  endtask

  initial begin
    bit r;
    logic [2:0] sel;
    logic [3:0] tt;
    int w;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_r[i] = 1'b0;
      sel_r[i]   = 3'd0;
      tt_r[i]    = 4'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_busy", busy_w[i], 0);
      check("rst_done", done_w[i], 0);
      check("rst_pass", pass_w[i], 0);
      check("rst_err", err_w[i], 0);
      check("rst_ab", {a_w[i], b_w[i], vidx_w[i]}, 0);
      check("rst_fail", {fvld_w[i], fvec_w[i]}, 0);
    end
    rst = 1'b0;

    run(0, 3'd2, 4'b0111, 0, 1'b0, r);   // good NAND
    run(0, 3'd2, 4'b1111, 0, 1'b0, r);   // stuck-at-1: single miss at {a,b}=11
    run(2, 3'd2, 4'b1000, 0, 1'b0, r);   // AND model, 3 passes
    run(0, 3'd7, 4'b0111, 0, 1'b0, r);   // illegal select with good NAND
    run(1, 3'd2, 4'b1111, 1, 1'b0, r);   // saturation at 3 with start noise
    run(0, 3'd4, 4'b0110, 2, 1'b0, r);   // start held across done
    if (r) run(0, 3'd4, 4'b0110, 0, 1'b1, r);

    // Reset in the middle of a run
    @(negedge clk);
    sel_r[0] = 3'd2; tt_r[0] = 4'b0000; start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy_w[0], 0);
    check("midrst_done", done_w[0], 0);
    check("midrst_err", err_w[0], 0);
    check("midrst_ab_idx", {a_w[0], b_w[0], vidx_w[0]}, 0);
    check("midrst_pass_fail", {pass_w[0], fvld_w[0], fvec_w[0]}, 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("no_done_after_rst", {done_w[0], busy_w[0]}, 0);
    end
    run(0, 3'd2, 4'b0111, 0, 1'b0, r);

    for (int n = 0; n < 30; n++) begin
      w   = int'($urandom_range(0, 2));
      sel = 3'($urandom);
      tt  = ($urandom_range(0, 1) == 1) ? ref_tt(int'(sel)) : 4'($urandom);
      run(w, sel, tt, int'($urandom_range(0, 2)), 1'b0, r);
      if (r) run(w, sel, tt, 0, 1'b1, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
